// File: rtl/cu_pipe.sv
//==============================================================================
// Module      : cu_pipe
// Description : ID-stage control decode with a registered EX control word,
//               load-use hazard bubbling, flush/freeze handling and a
//               saturating stall counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cu_pipe #(
    parameter int SUPPORT_SLT  = 1,
    parameter int ILLEGAL_TRAP = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic             flush_i,
    input  logic             mem_busy_i,
    output logic             ex_valid_o,
    output logic             ex_regWrite_o,
    output logic             ex_aluSrc1_o,
    output logic             ex_aluSrc2_o,
    output logic             ex_memWrite_o,
    output logic             ex_memRead_o,
    output logic             ex_jump_o,
    output logic             ex_lsReq_o,
    output logic [1:0]       ex_mem2reg_o,
    output logic [3:0]       ex_aluOp_o,
    output logic [2:0]       ex_branchContr_o,
    output logic [4:0]       ex_rd_o,
    output logic             ex_illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [3:0] c_ALU_ADD  = 4'b0001;
    localparam logic [3:0] c_ALU_SUB  = 4'b0010;
    localparam logic [3:0] c_ALU_AND  = 4'b0011;
    localparam logic [3:0] c_ALU_OR   = 4'b0100;
    localparam logic [3:0] c_ALU_XOR  = 4'b0101;
    localparam logic [3:0] c_ALU_SLL  = 4'b0110;
    localparam logic [3:0] c_ALU_SRL  = 4'b0111;
    localparam logic [3:0] c_ALU_SRA  = 4'b1000;
    localparam logic [3:0] c_ALU_SLT  = 4'b1001;
    localparam logic [3:0] c_ALU_SLTU = 4'b1010;

    localparam logic       c_SLT_EN   = (SUPPORT_SLT != 0);
    localparam logic       c_TRAP_EN  = (ILLEGAL_TRAP != 0);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       alu_src1;
        logic       alu_src2;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] mem2reg;
        logic       jump;
        logic       ls_req;
        logic [3:0] alu_op;
        logic [2:0] branch;
        logic [4:0] rd;
        logic       illegal;
    } ex_t;

    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic             w_known;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_hazard;
    ex_t              w_raw;
    ex_t              w_dec;
    ex_t              w_ex_nxt;
    logic             w_ex_load;
    logic             w_cnt_inc;
    logic             w_unused_bits;
    ex_t              r_ex;
    logic [CNT_W-1:0] r_cnt;

    assign w_opcode      = instr_i[6:0];
    assign w_f3          = instr_i[14:12];
    assign w_rs1         = instr_i[19:15];
    assign w_rs2         = instr_i[24:20];
    assign w_unused_bits = ^{instr_i[31], instr_i[29:25]};

    // Combinational decode of the ID instruction into a raw control word
    always_comb begin
        w_raw      = '0;
        w_known    = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        case (w_opcode)
            c_OP_LOAD: begin
                w_raw.reg_write = 1'b1;
                w_raw.alu_src1  = 1'b1;
                w_raw.alu_src2  = 1'b1;
                w_raw.mem_read  = 1'b1;
                w_raw.mem2reg   = 2'b01;
                w_raw.ls_req    = 1'b1;
                w_raw.alu_op    = c_ALU_ADD;
            end
            c_OP_STORE: begin
                w_raw.alu_src1  = 1'b1;
                w_raw.alu_src2  = 1'b1;
                w_raw.mem_write = 1'b1;
                w_raw.ls_req    = 1'b1;
                w_raw.alu_op    = c_ALU_ADD;
                w_rs2_used      = 1'b1;
            end
            c_OP_OP: begin
                w_raw.reg_write = 1'b1;
                w_raw.alu_src2  = 1'b1;
                w_rs2_used      = 1'b1;
                case ({instr_i[30], w_f3})
                    4'b0_000: w_raw.alu_op = c_ALU_ADD;
                    4'b1_000: w_raw.alu_op = c_ALU_SUB;
                    4'b0_001: w_raw.alu_op = c_ALU_SLL;
                    4'b0_101: w_raw.alu_op = c_ALU_SRL;
                    4'b1_101: w_raw.alu_op = c_ALU_SRA;
                    4'b0_100: w_raw.alu_op = c_ALU_XOR;
                    4'b0_111: w_raw.alu_op = c_ALU_AND;
                    4'b0_110: w_raw.alu_op = c_ALU_OR;
                    4'b0_010: begin
                        w_raw.alu_op = c_ALU_SLT;
                        w_known      = c_SLT_EN;
                    end
                    4'b0_011: begin
                        w_raw.alu_op = c_ALU_SLTU;
                        w_known      = c_SLT_EN;
                    end
                    default:  w_known = 1'b0;
                endcase
            end
            c_OP_IMM: begin
                w_raw.reg_write = 1'b1;
                w_raw.alu_src1  = 1'b1;
                w_raw.alu_src2  = 1'b1;
                // Only the shift-right encoding looks at bit 30; addi ignores it
                case (w_f3)
                    3'b000:  w_raw.alu_op = c_ALU_ADD;
                    3'b001:  w_raw.alu_op = c_ALU_SLL;
                    3'b101:  w_raw.alu_op = instr_i[30] ? c_ALU_SRA : c_ALU_SRL;
                    3'b100:  w_raw.alu_op = c_ALU_XOR;
                    3'b111:  w_raw.alu_op = c_ALU_AND;
                    3'b110:  w_raw.alu_op = c_ALU_OR;
                    3'b010: begin
                        w_raw.alu_op = c_ALU_SLT;
                        w_known      = c_SLT_EN;
                    end
                    default: begin
                        w_raw.alu_op = c_ALU_SLTU;
                        w_known      = c_SLT_EN;
                    end
                endcase
            end
            c_OP_AUIPC, c_OP_LUI: begin
                w_raw.reg_write = 1'b1;
                w_raw.alu_src1  = 1'b1;
                w_raw.alu_op    = c_ALU_ADD;
                w_rs1_used      = 1'b0;
            end
            c_OP_BRANCH: begin
                w_raw.alu_op = c_ALU_ADD;
                w_rs2_used   = 1'b1;
                case (w_f3)
                    3'b000:  w_raw.branch = 3'b001;
                    3'b001:  w_raw.branch = 3'b010;
                    3'b101:  w_raw.branch = 3'b011;
                    3'b110:  w_raw.branch = 3'b100;
                    3'b111:  w_raw.branch = 3'b101;
                    3'b100: begin
                        w_raw.branch = 3'b110;
                        w_known      = c_SLT_EN;
                    end
                    default: w_known = 1'b0;
                endcase
            end
            c_OP_JAL, c_OP_JALR: begin
                w_raw.reg_write = 1'b1;
                w_raw.alu_src1  = 1'b1;
                w_raw.alu_src2  = (w_opcode == c_OP_JALR);
                w_raw.mem2reg   = 2'b10;
                w_raw.jump      = 1'b1;
                w_raw.alu_op    = c_ALU_ADD;
                w_rs1_used      = (w_opcode == c_OP_JALR);
            end
            default: w_known = 1'b0;
        endcase
    end

    // Final EX word: known decode, illegal marker entry, or bubble
    always_comb begin
        w_dec = '0;
        if (w_known) begin
            w_dec       = w_raw;
            w_dec.valid = 1'b1;
            w_dec.rd    = w_raw.reg_write ? instr_i[11:7] : 5'd0;
        end else if (c_TRAP_EN) begin
            w_dec.valid   = 1'b1;
            w_dec.illegal = 1'b1;
        end
    end

    // Load-use: EX load result is needed by a source the ID instruction reads
    assign w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == r_ex.rd)) ||
                       (w_rs2_used && (w_rs2 == r_ex.rd)));

    // Per-cycle arbitration: freeze > flush > load-use stall > accept > idle
    always_comb begin
        instr_ready_o = 1'b0;
        w_ex_load     = 1'b1;
        w_ex_nxt      = '0;
        w_cnt_inc     = 1'b0;
        if (mem_busy_i) begin
            w_ex_load = 1'b0;
        end else if (flush_i) begin
            instr_ready_o = 1'b1;
        end else if (instr_valid_i && w_hazard) begin
            w_cnt_inc = 1'b1;
        end else if (instr_valid_i) begin
            instr_ready_o = 1'b1;
            w_ex_nxt      = w_dec;
        end
    end

    // EX control register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (w_ex_load) begin
            r_ex <= w_ex_nxt;
        end
    end

    // Saturating load-use bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid_o       = r_ex.valid;
    assign ex_regWrite_o    = r_ex.reg_write;
    assign ex_aluSrc1_o     = r_ex.alu_src1;
    assign ex_aluSrc2_o     = r_ex.alu_src2;
    assign ex_memWrite_o    = r_ex.mem_write;
    assign ex_memRead_o     = r_ex.mem_read;
    assign ex_jump_o        = r_ex.jump;
    assign ex_lsReq_o       = r_ex.ls_req;
    assign ex_mem2reg_o     = r_ex.mem2reg;
    assign ex_aluOp_o       = r_ex.alu_op;
    assign ex_branchContr_o = r_ex.branch;
    assign ex_rd_o          = r_ex.rd;
    assign ex_illegal_o     = r_ex.illegal;
    assign stall_cnt_o      = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cu_pipe.sv
//==============================================================================
// Module      : tb_cu_pipe
// Description : Directed scoreboard bench for cu_pipe (default build plus a
//               SUPPORT_SLT=0 build sharing the same stimulus).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cu_pipe;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       a1;
        logic       a2;
        logic       mw;
        logic       mr;
        logic [1:0] m2r;
        logic       j;
        logic       ls;
        logic [3:0] op;
        logic [2:0] br;
        logic [4:0] rd;
        logic       ill;
    } exw_t;

    typedef struct packed {
        exw_t       ex;
        logic [7:0] cnt;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        instr_valid_i, flush_i, mem_busy_i;

    logic       rdy, v, rw, a1, a2, mw, mr, j, ls, ill;
    logic [1:0] m2r;
    logic [3:0] op;
    logic [2:0] br;
    logic [4:0] rd;
    logic [7:0] cnt;

    logic       n_rdy, n_v, n_rw, n_a1, n_a2, n_mw, n_mr, n_j, n_ls, n_ill;
    logic [1:0] n_m2r;
    logic [3:0] n_op;
    logic [2:0] n_br;
    logic [4:0] n_rd;
    logic [7:0] n_cnt;

    int   checks   = 0;
    int   failures = 0;
    exw_t ex_m     = '0;
    logic [7:0] cnt_m = 8'd0;
    sb_t  sbq[$];

    always #5 clk = ~clk;

    cu_pipe #(.SUPPORT_SLT(1), .ILLEGAL_TRAP(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(rdy), .flush_i(flush_i), .mem_busy_i(mem_busy_i),
        .ex_valid_o(v), .ex_regWrite_o(rw), .ex_aluSrc1_o(a1), .ex_aluSrc2_o(a2),
        .ex_memWrite_o(mw), .ex_memRead_o(mr), .ex_jump_o(j), .ex_lsReq_o(ls),
        .ex_mem2reg_o(m2r), .ex_aluOp_o(op), .ex_branchContr_o(br), .ex_rd_o(rd),
        .ex_illegal_o(ill), .stall_cnt_o(cnt)
    );

    cu_pipe #(.SUPPORT_SLT(0), .ILLEGAL_TRAP(1), .CNT_W(8)) dut_noslt (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(n_rdy), .flush_i(flush_i), .mem_busy_i(mem_busy_i),
        .ex_valid_o(n_v), .ex_regWrite_o(n_rw), .ex_aluSrc1_o(n_a1), .ex_aluSrc2_o(n_a2),
        .ex_memWrite_o(n_mw), .ex_memRead_o(n_mr), .ex_jump_o(n_j), .ex_lsReq_o(n_ls),
        .ex_mem2reg_o(n_m2r), .ex_aluOp_o(n_op), .ex_branchContr_o(n_br), .ex_rd_o(n_rd),
        .ex_illegal_o(n_ill), .stall_cnt_o(n_cnt)
    );

    function automatic exw_t mk(input logic vv, rww, a1v, a2v, mwv, mrv,
                                input logic [1:0] m2rv, input logic jv, lsv,
                                input logic [3:0] opv, input logic [2:0] brv,
                                input logic [4:0] rdv, input logic illv);
        exw_t e;
        e = '{vv, rww, a1v, a2v, mwv, mrv, m2rv, jv, lsv, opv, brv, rdv, illv};
        return e;
    endfunction

    function automatic exw_t obs();
        return mk(v, rw, a1, a2, mw, mr, m2r, j, ls, op, br, rd, ill);
    endfunction

    function automatic logic [31:0] rins(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rdv, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rdv, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock of stimulus: expectation queued at drive time, compared after the edge
    task automatic step(input string tag, input logic [31:0] ins, input logic vl,
                        input logic fl, input logic bz, input logic exp_rdy,
                        input exw_t exp_ex, input logic stall);
        sb_t  e;
        sb_t  got;
        @(negedge clk);
        instr_i       = ins;
        instr_valid_i = vl;
        flush_i       = fl;
        mem_busy_i    = bz;
        #1;
        chk({tag, "_ready"}, {31'd0, rdy}, {31'd0, exp_rdy});
        if (stall && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
        if (!bz) ex_m = exp_ex;
        e.ex  = ex_m;
        e.cnt = cnt_m;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sbq.pop_front();
            chk({tag, "_ex"}, {9'd0, obs()}, {9'd0, got.ex});
            chk({tag, "_cnt"}, {24'd0, cnt}, {24'd0, got.cnt});
        end
    endtask

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    initial begin
        logic [31:0] lw5, add6, sub3, blt, ori7, srai8, addi9, jal1, sw, lui10;
        logic [31:0] xor4, lw0, add0, bad;
        exw_t e_lw5, e_add6, e_ori7, e_bub;
        lw5   = rins(7'd0, 5'd0, 5'd2, 3'b010, 5'd5, OPC_LW);
        add6  = rins(7'd0, 5'd1, 5'd5, 3'b000, 5'd6, OPC_R);
        sub3  = rins(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, OPC_R);
        blt   = rins(7'd0, 5'd2, 5'd1, 3'b100, 5'd0, OPC_BR);
        ori7  = rins(7'd2, 5'd21, 5'd1, 3'b110, 5'd7, OPC_I);
        srai8 = rins(7'b0100000, 5'd3, 5'd1, 3'b101, 5'd8, OPC_I);
        addi9 = rins(7'b0100000, 5'd3, 5'd1, 3'b000, 5'd9, OPC_I);
        jal1  = rins(7'd0, 5'd2, 5'd0, 3'b000, 5'd1, OPC_JAL);
        sw    = rins(7'd0, 5'd5, 5'd2, 3'b010, 5'd0, OPC_SW);
        lui10 = rins(7'd0, 5'd0, 5'd5, 3'b000, 5'd10, OPC_LUI);
        xor4  = rins(7'd0, 5'd5, 5'd1, 3'b100, 5'd4, OPC_R);
        lw0   = rins(7'd0, 5'd0, 5'd2, 3'b010, 5'd0, OPC_LW);
        add0  = rins(7'd0, 5'd1, 5'd0, 3'b000, 5'd6, OPC_R);
        bad   = 32'h00A5_0FFF;

        e_bub  = '0;
        e_lw5  = mk(1, 1, 1, 1, 0, 1, 2'b01, 0, 1, 4'b0001, 3'b000, 5'd5, 0);
        e_add6 = mk(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 4'b0001, 3'b000, 5'd6, 0);
        e_ori7 = mk(1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 4'b0100, 3'b000, 5'd7, 0);

        rst_n = 1'b0; instr_i = '0; instr_valid_i = 1'b0; flush_i = 1'b0; mem_busy_i = 1'b0;
        #1;
        chk("reset_ex_async", {9'd0, obs()}, 32'd0);
        chk("reset_cnt_async", {24'd0, cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step("idle",     32'd0, 0, 0, 0, 0, e_bub, 0);
        step("lw5",      lw5,   1, 0, 0, 1, e_lw5, 0);
        step("add_haz",  add6,  1, 0, 0, 0, e_bub, 1);
        step("add_go",   add6,  1, 0, 0, 1, e_add6, 0);
        step("sub",      sub3,  1, 0, 0, 1,
             mk(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 4'b0010, 3'b000, 5'd3, 0), 0);
        step("blt",      blt,   1, 0, 0, 1,
             mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0001, 3'b110, 5'd0, 0), 0);
        chk("blt_noslt_valid", {31'd0, n_v}, 32'd1);
        chk("blt_noslt_ill", {31'd0, n_ill}, 32'd1);
        chk("blt_noslt_rw", {31'd0, n_rw}, 32'd0);
        chk("blt_noslt_br", {29'd0, n_br}, 32'd0);

        step("ori",      ori7,  1, 0, 0, 1, e_ori7, 0);
        for (int i = 0; i < 3; i++)
            step("busy_flush", add6, 1, 1, 1, 0, e_bub, 0);
        step("flush",    add6,  1, 1, 0, 1, e_bub, 0);
        step("srai",     srai8, 1, 0, 0, 1,
             mk(1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 4'b1000, 3'b000, 5'd8, 0), 0);
        step("addi30",   addi9, 1, 0, 0, 1,
             mk(1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 4'b0001, 3'b000, 5'd9, 0), 0);
        step("jal",      jal1,  1, 0, 0, 1,
             mk(1, 1, 1, 0, 0, 0, 2'b10, 1, 0, 4'b0001, 3'b000, 5'd1, 0), 0);
        step("sw",       sw,    1, 0, 0, 1,
             mk(1, 0, 1, 1, 1, 0, 2'b00, 0, 1, 4'b0001, 3'b000, 5'd0, 0), 0);
        step("lw5b",     lw5,   1, 0, 0, 1, e_lw5, 0);
        step("lui_norel", lui10, 1, 0, 0, 1,
             mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 4'b0001, 3'b000, 5'd10, 0), 0);
        step("lw5c",     lw5,   1, 0, 0, 1, e_lw5, 0);
        step("xor_haz",  xor4,  1, 0, 0, 0, e_bub, 1);
        step("xor_go",   xor4,  1, 0, 0, 1,
             mk(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 4'b0101, 3'b000, 5'd4, 0), 0);
        step("lw_x0",    lw0,   1, 0, 0, 1,
             mk(1, 1, 1, 1, 0, 1, 2'b01, 0, 1, 4'b0001, 3'b000, 5'd0, 0), 0);
        step("add_x0",   add0,  1, 0, 0, 1, e_add6, 0);

        for (int i = 0; i < 300; i++) begin
            step("sat_lw",  lw5,  1, 0, 0, 1, e_lw5, 0);
            step("sat_haz", add6, 1, 0, 0, 0, e_bub, 1);
        end
        chk("sat_255", {24'd0, cnt}, 32'd255);

        // Reset asserted between edges while a load-use stall is pending
        step("pre_rst_lw", lw5, 1, 0, 0, 1, e_lw5, 0);
        @(negedge clk);
        instr_i = add6; instr_valid_i = 1'b1;
        #1;
        chk("pre_rst_ready", {31'd0, rdy}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ex", {9'd0, obs()}, 32'd0);
        chk("rst_mid_cnt", {24'd0, cnt}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_ex", {9'd0, obs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; instr_valid_i = 1'b0;
        ex_m = '0; cnt_m = 8'd0;

        step("illegal",  bad,   1, 0, 0, 1,
             mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000, 3'b000, 5'd0, 1), 0);
        chk("illegal_noslt", {31'd0, n_ill}, 32'd1);
        step("tail_idle", 32'd0, 0, 0, 0, 0, e_bub, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cu_pipe.md
CU_PIPE -- requirements
Module: cu_pipe

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameters, one per line, SHALL be:
- SUPPORT_SLT, default 1: decode slt/sltu/slti/sltiu and blt.
- ILLEGAL_TRAP, default 1: flag unknown opcodes instead of producing X.
- CNT_W, default 8: width of the stall counter.
REQ-003 Ports, one per line, SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- instr_i  in  32  instruction in ID.
- instr_valid_i  in  1  instr_i valid.
- instr_ready_o  out  1  ID consumes instr_i this cycle.
- flush_i  in  1  taken branch/jump from EX; kill ID.
- mem_busy_i  in  1  data memory not ready; freeze.
- ex_valid_o  out  1  EX control register holds an instruction.
- ex_regWrite_o, ex_aluSrc1_o, ex_aluSrc2_o, ex_memWrite_o, ex_memRead_o, ex_jump_o, ex_lsReq_o  out  1 each  registered control.
- ex_mem2reg_o  out  2  writeback select.
- ex_aluOp_o  out  4  ALU operation.
- ex_branchContr_o  out  3  branch type.
- ex_rd_o  out  5  destination register.
- ex_illegal_o  out  1  unknown opcode in EX.
- stall_cnt_o  out  CNT_W  load-use bubble count.

Function
REQ-004 Decode SHALL be combinational on instr_i; all ex_* outputs SHALL be registered, giving 1-cycle latency from accept to EX.
REQ-005 Control word {regWrite,aluSrc1,aluSrc2,memWrite,memRead,mem2reg,jump,lsReq} SHALL be:
- LW 0000011: 1,1,1,0,1,01,0,1.
- SW 0100011: 0,1,1,1,0,00,0,1.
- R-type 0110011: 1,0,1,0,0,00,0,0.
- OP-IMM 0010011: 1,1,1,0,0,00,0,0.
- AUIPC 0010111: 1,1,0,0,0,00,0,0.
- LUI 0110111: 1,1,0,0,0,00,0,0.
- BRANCH 1100011: 0,0,0,0,0,00,0,0.
- JAL 1101111: 1,1,0,0,0,10,1,0.
- JALR 1100111: 1,1,1,0,0,10,1,0.
REQ-006 aluOp SHALL be add 0001 for LW/SW/AUIPC/LUI/JAL/JALR/BRANCH.
REQ-007 For R-type, aluOp SHALL be selected by {instr[30],func3}: add 0001, sub 0010, sll 0110, srl 0111, sra 1000, xor 0101, and 0011, or 0100, slt 1001, sltu 1010.
REQ-008 OP-IMM SHALL use the same func3 mapping as R-type, with instr[30] honoured only for func3=101 (srai); addi with instr[30]=1 SHALL be add.
REQ-009 branchContr SHALL be: beq 001, bne 010, bge 011, bltu 100, bgeu 101, blt 110; non-branch 000.
REQ-010 With SUPPORT_SLT=0, slt/sltu/slti/sltiu/blt SHALL be treated as unknown.
REQ-011 Unknown opcode or funct combination SHALL load a valid entry with ex_illegal_o=1 and all write/mem/jump/lsReq controls 0 (ILLEGAL_TRAP=1); with ILLEGAL_TRAP=0 it SHALL load a bubble.
REQ-012 A bubble SHALL be ex_valid_o=0 with all other ex_* outputs 0.
REQ-013 ex_rd_o SHALL be instr[11:7] for writing instructions and 0 otherwise.
REQ-014 Load-use hazard SHALL be: ex_valid_o & ex_memRead_o & ex_rd_o!=0 & (rd==rs1 where rs1 is used, or rd==rs2 where rs2 is used).
REQ-015 rs1 SHALL be used by all instructions except LUI/AUIPC/JAL; rs2 SHALL be used by R-type/SW/BRANCH.
REQ-016 Per-cycle priority, highest first:
- mem_busy_i: EX register holds, instr_ready_o=0, counter holds.
- flush_i: EX loads bubble, instr_ready_o=1 (ID instruction discarded).
- hazard with instr_valid_i: EX loads bubble, instr_ready_o=0, stall_cnt_o increments.
- instr_valid_i: EX loads decode, instr_ready_o=1.
- otherwise: EX loads bubble, instr_ready_o=0.
REQ-017 instr_ready_o SHALL be combinational from current inputs and EX state.
REQ-018 stall_cnt_o SHALL saturate at all-ones and SHALL NOT wrap.

Reset
REQ-019 While rst_n=0, all ex_* outputs and stall_cnt_o SHALL be 0, independent of clk.
REQ-020 The first rising clk edge after rst_n rises SHALL obey REQ-016 normally.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- LW x5 then ADD x6,x5,x1 back-to-back -> one bubble, ready=0 one cycle, stall_cnt=1, then ADD in EX with aluOp=0001, regWrite=1.
- SUB x3,x1,x2 (instr[30]=1) -> next cycle ex_aluOp=0010, aluSrc1=0, aluSrc2=1, rd=3.
- BLT with SUPPORT_SLT=1 -> branchContr=110; with SUPPORT_SLT=0 -> ex_illegal_o=1, regWrite=0.
- mem_busy_i=1 for 3 cycles with flush_i=1 -> EX unchanged, ready=0; flush_i applies after busy drops.
- Force 300 hazards with CNT_W=8 -> stall_cnt_o=255.
- rst_n low mid-stall -> outputs 0 immediately; opcode 1111111 after reset -> ex_valid=1, ex_illegal=1.
